// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Front-end fetch sequencer. Holds the fetch PC, issues at most one
//   instruction-memory request at a time, and pushes each returned word into
//   the instruction queue together with its PC and branch prediction.
//   When the queue is full the returned word waits in a one-entry hold
//   buffer. A commit-side flush redirects the PC. If a flush arrives while a
//   request is in flight, the stale response is discarded when it returns.
//
// Configuration macro:
//   FETCH_PRED_EN : when defined, the next PC and iq_pred_* come from the BTB
//                   (btb_npc/btb_taken). When undefined, fetch is strictly
//                   sequential (pc + 4, predicted not-taken) and the btb_*
//                   inputs are ignored.
//
// Ports:
//   clk, rst          : clock; synchronous active-high reset
//   btb_pc            : current fetch PC presented to the BTB
//   btb_npc/btb_taken : BTB prediction for btb_pc
//   imem_addr         : instruction memory word address (always the fetch PC)
//   imem_rmask        : 4'hF = read request, 4'h0 = idle
//   imem_rdata        : returned instruction word
//   imem_resp         : single-cycle response strobe
//   flush/flush_pc    : redirect request and its target
//   iq_full           : instruction queue cannot accept a push this cycle
//   iq_push           : enqueue strobe
//   iq_inst/iq_pc     : enqueued instruction and its PC
//   iq_pred_npc/taken : prediction that travels with the instruction
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] btb_pc,
    input  logic [31:0] btb_npc,
    input  logic        btb_taken,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        iq_full,
    output logic        iq_push,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic [31:0] iq_pred_npc,
    output logic        iq_pred_taken
);

    typedef enum logic [1:0] {
        S_FETCH,    // request outstanding for pc_q
        S_STALL,    // word held, waiting for queue space
        S_DISCARD   // stale request in flight, drop its response
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_npc_q, hold_npc_d;
    logic        hold_taken_q, hold_taken_d;

    // Prediction for the word returning this cycle. The BTB is sampled in
    // the response cycle, so it always describes the PC that is returning.
    logic [31:0] pred_npc;
    logic        pred_taken;

`ifdef FETCH_PRED_EN
    assign pred_npc   = btb_npc;
    assign pred_taken = btb_taken;
`else
    logic unused_btb;
    assign pred_npc   = pc_q + 32'd4;
    assign pred_taken = 1'b0;
    assign unused_btb = ^{btb_npc, btb_taken};
`endif

    assign btb_pc    = pc_q;
    assign imem_addr = pc_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch can be inferred.
        state_d       = state_q;
        pc_d          = pc_q;
        hold_valid_d  = hold_valid_q;
        hold_inst_d   = hold_inst_q;
        hold_pc_d     = hold_pc_q;
        hold_npc_d    = hold_npc_q;
        hold_taken_d  = hold_taken_q;
        imem_rmask    = 4'h0;
        iq_push       = 1'b0;
        iq_inst       = imem_rdata;
        iq_pc         = pc_q;
        iq_pred_npc   = pred_npc;
        iq_pred_taken = pred_taken;

        unique case (state_q)
            S_FETCH: begin
                imem_rmask = 4'hF;
                if (flush) begin
                    pc_d = flush_pc;
                    // A coincident response completes the old request, so
                    // the redirect target can be requested right away.
                    state_d = imem_resp ? S_FETCH : S_DISCARD;
                end else if (imem_resp) begin
                    if (!iq_full) begin
                        iq_push = 1'b1;
                        pc_d    = pred_npc;
                    end else begin
                        hold_valid_d = 1'b1;
                        hold_inst_d  = imem_rdata;
                        hold_pc_d    = pc_q;
                        hold_npc_d   = pred_npc;
                        hold_taken_d = pred_taken;
                        state_d      = S_STALL;
                    end
                end
            end
            S_STALL: begin
                iq_inst       = hold_inst_q;
                iq_pc         = hold_pc_q;
                iq_pred_npc   = hold_npc_q;
                iq_pred_taken = hold_taken_q;
                if (flush) begin
                    hold_valid_d = 1'b0;
                    pc_d         = flush_pc;
                    state_d      = S_FETCH;
                end else if (!iq_full && hold_valid_q) begin
                    iq_push      = 1'b1;
                    hold_valid_d = 1'b0;
                    pc_d         = hold_npc_q;
                    state_d      = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (flush) begin
                    pc_d = flush_pc;
                end
                if (imem_resp) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // The reset cycle issues nothing; any response seen now belongs to
        // an abandoned request.
        if (rst) begin
            imem_rmask = 4'h0;
            iq_push    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // NOTE: the hold-buffer payload is not reset; it is only ever read while
    // hold_valid_q is set, so resetting it would add logic for nothing.
    always_ff @(posedge clk) begin
        hold_inst_q  <= hold_inst_d;
        hold_pc_q    <= hold_pc_d;
        hold_npc_q   <= hold_npc_d;
        hold_taken_q <= hold_taken_d;
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model (fetch PC, pending-drop flag, queue of held words).
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;
`ifdef FETCH_PRED_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] btb_pc, btb_npc = '0;
    logic        btb_taken = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [3:0]  imem_rmask;
    logic        imem_resp = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        iq_full = 1'b0;
    logic        iq_push;
    logic [31:0] iq_inst, iq_pc, iq_pred_npc;
    logic        iq_pred_taken;

    int checks = 0;
    int failures = 0;

    fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .btb_pc(btb_pc), .btb_npc(btb_npc), .btb_taken(btb_taken),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .flush(flush), .flush_pc(flush_pc),
        .iq_full(iq_full), .iq_push(iq_push),
        .iq_inst(iq_inst), .iq_pc(iq_pc),
        .iq_pred_npc(iq_pred_npc), .iq_pred_taken(iq_pred_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        taken;
    } entry_t;

    entry_t      held[$];        // words waiting for queue space
    logic [31:0] m_pc;           // address being fetched
    bit          m_drop;         // a stale response is still due
    bit          m_valid = 1'b0; // model synchronised by a reset
    bit          m_req, m_push;
    entry_t      m_e;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            check("rst_rmask", imem_rmask, 4'h0);
            check("rst_push", iq_push, 1'b0);
            m_pc    = RESET_PC;
            m_drop  = 1'b0;
            m_valid = 1'b1;
            held.delete();
        end else if (m_valid) begin
            m_req = (held.size() == 0) && !m_drop;
            check("m_rmask", imem_rmask, m_req ? 4'hF : 4'h0);
            check("m_addr", imem_addr, m_pc);
            check("m_btb_pc", btb_pc, m_pc);

            m_push = 1'b0;
            if (!flush && !iq_full) begin
                if (held.size() > 0) begin
                    m_push = 1'b1;
                    m_e    = held[0];
                end else if (m_req && imem_resp) begin
                    m_push   = 1'b1;
                    m_e.inst = imem_rdata;
                    m_e.pc   = m_pc;
                end
            end
            if (m_push && held.size() == 0) begin
                m_e.npc   = PRED_EN ? btb_npc : m_pc + 32'd4;
                m_e.taken = PRED_EN ? btb_taken : 1'b0;
            end
            check("m_push", iq_push, m_push);
            if (m_push) begin
                check("m_inst", iq_inst, m_e.inst);
                check("m_pc", iq_pc, m_e.pc);
                check("m_pred_npc", iq_pred_npc, m_e.npc);
                check("m_pred_taken", iq_pred_taken, m_e.taken);
            end

            // advance the model
            if (flush) begin
                held.delete();
                if (m_req && !imem_resp) m_drop = 1'b1;
                else if (m_drop && imem_resp) m_drop = 1'b0;
                m_pc = flush_pc;
            end else if (held.size() > 0) begin
                if (!iq_full) begin
                    m_pc = held[0].npc;
                    void'(held.pop_front());
                end
            end else if (m_drop) begin
                if (imem_resp) m_drop = 1'b0;
            end else if (imem_resp) begin
                m_e.inst  = imem_rdata;
                m_e.pc    = m_pc;
                m_e.npc   = PRED_EN ? btb_npc : m_pc + 32'd4;
                m_e.taken = PRED_EN ? btb_taken : 1'b0;
                if (iq_full) held.push_back(m_e);
                else m_pc = m_e.npc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r, input bit resp, input logic [31:0] rd,
                       input bit fl, input logic [31:0] fpc, input bit full,
                       input bit tk, input logic [31:0] npc);
        @(negedge clk);
        rst        = r;
        imem_resp  = resp;
        imem_rdata = rd;
        flush      = fl;
        flush_pc   = fpc;
        iq_full    = full;
        btb_taken  = tk;
        btb_npc    = npc;
        #2;
    endtask

    initial begin
        // reset and sequential fetch
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check("d_rst_rmask", imem_rmask, 4'h0);
        check("d_rst_push", iq_push, 1'b0);
        cyc(0, 1, 32'hA0, 0, 0, 0, 0, 32'h0);
        check("d_first_rmask", imem_rmask, 4'hF);
        check("d_first_addr", imem_addr, 32'h1eceb000);
        check("d_first_push", iq_push, 1'b1);
        check("d_first_pc", iq_pc, 32'h1eceb000);
        check("d_first_inst", iq_inst, 32'hA0);
        cyc(0, 1, 32'hA1, 0, 0, 0, 0, 32'h0);
        check("d_second_pc", iq_pc, 32'h1eceb004);
        cyc(0, 1, 32'hA2, 0, 0, 0, 1, 32'h1eceb100);
        check("d_third_pc", iq_pc, 32'h1eceb008);
`ifdef FETCH_PRED_EN
        check("d_taken", iq_pred_taken, 1'b1);
        check("d_taken_npc", iq_pred_npc, 32'h1eceb100);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("d_branch_addr", imem_addr, 32'h1eceb100);
`else
        check("d_nopred_taken", iq_pred_taken, 1'b0);
        check("d_nopred_npc", iq_pred_npc, 32'h1eceb00c);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("d_seq_addr", imem_addr, 32'h1eceb00c);
`endif

        // queue full on the response for 1eceb004
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'hB0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'hB1, 0, 0, 1, 0, 0);
        check("d_full_push", iq_push, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 0, 0);
            check("d_stall_rmask", imem_rmask, 4'h0);
            check("d_stall_push", iq_push, 1'b0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("d_release_push", iq_push, 1'b1);
        check("d_release_pc", iq_pc, 32'h1eceb004);
        check("d_release_inst", iq_inst, 32'hB1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("d_after_stall_addr", imem_addr, 32'h1eceb008);
        check("d_after_stall_rmask", imem_rmask, 4'hF);

        // flush while waiting: next response dropped
        cyc(0, 0, 0, 1, 32'h1eceb200, 0, 0, 0);
        check("d_flush_push", iq_push, 1'b0);
        cyc(0, 1, 32'hDEAD, 0, 0, 0, 0, 0);
        check("d_drop_push", iq_push, 1'b0);
        check("d_drop_rmask", imem_rmask, 4'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("d_redirect_addr", imem_addr, 32'h1eceb200);
        check("d_redirect_rmask", imem_rmask, 4'hF);

        // flush coincident with a response
        cyc(0, 1, 32'hC0, 1, 32'h1eceb300, 0, 0, 0);
        check("d_coinc_push", iq_push, 1'b0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("d_coinc_addr", imem_addr, 32'h1eceb300);
        check("d_coinc_rmask", imem_rmask, 4'hF);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom_range(99) < 2),
                ($urandom_range(99) < 55),
                $urandom,
                ($urandom_range(99) < 10),
                {$urandom_range(32'h3fffffff), 2'b00},
                ($urandom_range(99) < 35),
                $urandom_range(1),
                {$urandom_range(32'h3fffffff), 2'b00});
        end
        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
